// File: rtl/reflet_cpu_core_pkg.sv
// reflet_pkg: shared definitions for the reflet accumulator CPU.
// Holds the opcode map (high nibble of the instruction byte), the
// sub-codes of the misc opcode (low nibble when op is 0), the indices
// of registers with a dedicated role, and the control FSM state type.
package reflet_pkg;

  localparam logic [3:0] OP_MISC  = 4'h0;
  localparam logic [3:0] OP_SET   = 4'h1;
  localparam logic [3:0] OP_READ  = 4'h2;
  localparam logic [3:0] OP_CPY   = 4'h3;
  localparam logic [3:0] OP_ADD   = 4'h4;
  localparam logic [3:0] OP_SUB   = 4'h5;
  localparam logic [3:0] OP_AND   = 4'h6;
  localparam logic [3:0] OP_OR    = 4'h7;
  localparam logic [3:0] OP_XOR   = 4'h8;
  localparam logic [3:0] OP_NOT   = 4'h9;
  localparam logic [3:0] OP_LSL   = 4'hA;
  localparam logic [3:0] OP_LSR   = 4'hB;
  localparam logic [3:0] OP_CMP   = 4'hC;
  localparam logic [3:0] OP_JIF   = 4'hD;
  localparam logic [3:0] OP_LOAD  = 4'hE;
  localparam logic [3:0] OP_STORE = 4'hF;

  localparam logic [3:0] MISC_NOP   = 4'h0;
  localparam logic [3:0] MISC_DEBUG = 4'h1;
  localparam logic [3:0] MISC_QUIT  = 4'h2;
  localparam logic [3:0] MISC_JMP   = 4'h3;

  localparam logic [3:0] REG_WR = 4'd0;
  localparam logic [3:0] REG_SR = 4'd12;
  localparam logic [3:0] REG_SP = 4'd13;
  localparam logic [3:0] REG_PC = 4'd14;

  typedef enum logic [2:0] {
    FETCH,
    EXEC,
    MEM,
    LWAIT,
    HALT
  } state_t;

endpackage

// File: rtl/reflet_cpu_core_if.sv
// reflet_cpu_core_if: single synchronous memory bus of the reflet core.
//   addr      byte address driven by the core
//   data_out  store data driven by the core
//   write_en  store strobe driven by the core
//   data_in   read data, valid one cycle after addr
// master = CPU side, slave = memory side.
interface reflet_cpu_core_if #(
  parameter int wordsize = 16
);

  logic [wordsize-1:0] addr;
  logic [wordsize-1:0] data_out;
  logic [wordsize-1:0] data_in;
  logic                write_en;

  modport master (
    output addr,
    output data_out,
    output write_en,
    input  data_in
  );

  modport slave (
    input  addr,
    input  data_out,
    input  write_en,
    output data_in
  );

endinterface

// File: rtl/reflet_cpu_core_alu.sv
// reflet_alu: combinational datapath of the reflet core.
//   op      instruction opcode (high nibble)
//   wr      accumulator value
//   rr      value of the register selected by the low nibble
//   result  new accumulator value for READ/ADD..LSR (wr otherwise)
//   eq, lt  compare flags (lt is unsigned)
module reflet_alu
  import reflet_pkg::*;
#(
  parameter int wordsize = 16
) (
  input  logic [3:0]          op,
  input  logic [wordsize-1:0] wr,
  input  logic [wordsize-1:0] rr,
  output logic [wordsize-1:0] result,
  output logic                eq,
  output logic                lt
);

  always_comb begin
    result = wr;
    case (op)
      OP_READ: result = rr;
      OP_ADD:  result = wr + rr;
      OP_SUB:  result = wr - rr;
      OP_AND:  result = wr & rr;
      OP_OR:   result = wr | rr;
      OP_XOR:  result = wr ^ rr;
      OP_NOT:  result = ~rr;
      // Shift counts past the word width naturally yield zero.
      OP_LSL:  result = wr << rr[4:0];
      OP_LSR:  result = wr >> rr[4:0];
      default: result = wr;
    endcase
  end

  assign eq = (wr == rr);
  assign lt = (wr < rr);

endmodule

// File: rtl/reflet_cpu_core.sv
// reflet_cpu_core: accumulator CPU with 8-bit instructions.
//   clk, reset         rising-edge clock, synchronous active-high reset
//   enable             low freezes all state and suppresses write_en/debug
//   interrupt_request  reserved, ignored
//   bus (master)       byte-addressed memory bus, 1-cycle read latency
//   quit               sticky, set by QUIT, cleared by reset
//   debug              one-cycle pulse per executed DEBUG
// Register file: R0=WR, R12=SR (bit0 EQ, bit1 LT), R13=SP, R14=PC.
module reflet_cpu_core
  import reflet_pkg::*;
#(
  parameter int wordsize = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [3:0]         interrupt_request,
  reflet_cpu_core_if.master  bus,
  output logic               quit,
  output logic               debug
);

  logic [wordsize-1:0] regs [16];
  state_t              state;
  logic [wordsize-1:0] addr_q;
  logic [wordsize-1:0] dout_q;
  logic                we_q;
  logic                dbg_q;
  logic                quit_q;

  logic [7:0]          instr;
  logic [3:0]          op;
  logic [3:0]          r;
  logic [wordsize-1:0] wr;
  logic [wordsize-1:0] rv;
  logic [wordsize-1:0] pc;
  logic [wordsize-1:0] pc_inc;
  logic [wordsize-1:0] alu_res;
  logic                alu_eq;
  logic                alu_lt;
  logic                unused_irq;

  assign unused_irq = ^interrupt_request;

  assign pc     = regs[REG_PC];
  assign wr     = regs[REG_WR];
  assign pc_inc = pc + wordsize'(1);
  assign instr  = pc[0] ? bus.data_in[15:8] : bus.data_in[7:0];
  assign op     = instr[7:4];
  assign r      = instr[3:0];
  // R14 holds the PC of the instruction in EXEC, so reading it yields
  // the address of the current instruction.
  assign rv     = regs[r];

  reflet_alu #(
    .wordsize(wordsize)
  ) u_alu (
    .op    (op),
    .wr    (wr),
    .rr    (rv),
    .result(alu_res),
    .eq    (alu_eq),
    .lt    (alu_lt)
  );

  // addr is registered one step ahead: whichever state comes next finds
  // its address already on the bus, so the 1-cycle memory latency is
  // absorbed without extra states (plain 2, STORE 3, LOAD 4 cycles).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 16; i++) regs[i] <= '0;
      state  <= FETCH;
      addr_q <= '0;
      dout_q <= '0;
      we_q   <= 1'b0;
      dbg_q  <= 1'b0;
      quit_q <= 1'b0;
    end else if (enable) begin
      dbg_q <= 1'b0;
      case (state)
        FETCH: begin
          addr_q <= pc;
          state  <= EXEC;
        end
        EXEC: begin
          regs[REG_PC] <= pc_inc;
          addr_q       <= pc_inc;
          state        <= FETCH;
          case (op)
            OP_MISC: begin
              case (r)
                MISC_NOP:   ;
                MISC_DEBUG: dbg_q <= 1'b1;
                MISC_QUIT: begin
                  quit_q <= 1'b1;
                  addr_q <= addr_q;
                  state  <= HALT;
                end
                MISC_JMP: begin
                  regs[REG_PC] <= wr;
                  addr_q       <= wr;
                end
                default: ;
              endcase
            end
            OP_SET: regs[REG_WR] <= wordsize'(r);
            OP_CPY: begin
              // Later assignment wins: CPY into R14 overrides the increment.
              regs[r] <= wr;
              if (r == REG_PC) addr_q <= wr;
            end
            OP_CMP: regs[REG_SR] <= {regs[REG_SR][wordsize-1:2], alu_lt, alu_eq};
            OP_JIF: begin
              if (regs[REG_SR][0]) begin
                regs[REG_PC] <= rv;
                addr_q       <= rv;
              end
            end
            OP_LOAD: begin
              addr_q <= rv;
              state  <= MEM;
            end
            OP_STORE: begin
              addr_q <= rv;
              dout_q <= wr;
              we_q   <= 1'b1;
              state  <= MEM;
            end
            default: regs[REG_WR] <= alu_res;
          endcase
        end
        MEM: begin
          if (we_q) begin
            we_q   <= 1'b0;
            addr_q <= pc;
            state  <= FETCH;
          end else begin
            state <= LWAIT;
          end
        end
        LWAIT: begin
          regs[REG_WR] <= bus.data_in;
          addr_q       <= pc;
          state        <= FETCH;
        end
        HALT: state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

  // Strobes are gated by enable so a frozen core never writes or
  // signals; the held registers re-assert them once enable returns.
  assign bus.addr     = addr_q;
  assign bus.data_out = dout_q;
  assign bus.write_en = we_q & enable;
  assign debug        = dbg_q & enable;
  assign quit         = quit_q;

endmodule

// File: tb/tb_reflet_cpu_core.sv
module tb_reflet_cpu_core;

  localparam int WS   = 16;
  localparam int MEMW = 32768;
  localparam int MAXC = 1200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic [3:0] irq = 4'hF;
  logic       quit;
  logic       debug;

  reflet_cpu_core_if #(.wordsize(WS)) bus ();

  reflet_cpu_core #(.wordsize(WS)) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .interrupt_request(irq),
    .bus              (bus),
    .quit             (quit),
    .debug            (debug)
  );

  always #5 clk = ~clk;

  // Word-wide synchronous memory, byte addressed via addr[15:1].
  logic [15:0] ram [MEMW];
  logic [15:0] img [MEMW];
  logic        load_mem = 1'b0;

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < MEMW; i++) ram[i] <= img[i];
    end else begin
      bus.data_in <= ram[bus.addr[15:1]];
      if (bus.write_en) ram[bus.addr[15:1]] <= bus.data_out;
    end
  end

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model results, indexed by effective (enabled) cycle.
  int          exp_fetch [MAXC];
  bit          exp_we    [MAXC];
  logic [15:0] exp_wa    [MAXC];
  logic [15:0] exp_wd    [MAXC];
  bit          exp_dbg   [MAXC];
  int          exp_dbg_n;
  int          exp_st_n;
  int          quit_at;
  bit          model_ok;
  logic [15:0] mm [MEMW];

  // Observations from the latest run.
  logic [15:0] obs_fetch [$];
  logic [15:0] obs_wa [$];
  logic [15:0] obs_wd [$];
  int          dbg_seen;

  // Instruction-level interpreter: each instruction starts with its fetch
  // at cycle t and costs 2 (plain), 3 (STORE) or 4 (LOAD) cycles; its
  // visible effects (debug, quit, write strobe) land at cycle t+2.
  task automatic model_run();
    logic [15:0] R [16];
    logic [15:0] pc, npc, w, v;
    logic [7:0]  ins;
    int          t, op, r, cost, sh;
    bit          halted;
    for (int i = 0; i < MAXC; i++) begin
      exp_fetch[i] = -1; exp_we[i] = 0; exp_dbg[i] = 0; exp_wa[i] = '0; exp_wd[i] = '0;
    end
    for (int i = 0; i < MEMW; i++) mm[i] = img[i];
    for (int i = 0; i < 16; i++) R[i] = '0;
    pc = '0; t = 0; halted = 0; quit_at = MAXC; exp_dbg_n = 0; exp_st_n = 0;
    while (!halted && t < MAXC - 8) begin
      w    = mm[pc[15:1]];
      ins  = pc[0] ? w[15:8] : w[7:0];
      op   = int'(ins[7:4]);
      r    = int'(ins[3:0]);
      v    = (r == 14) ? pc : R[r];
      exp_fetch[t] = int'(pc);
      npc  = pc + 16'd1;
      cost = 2;
      sh   = int'(v[4:0]);
      case (op)
        0: begin
          if (r == 1) begin exp_dbg[t+2] = 1; exp_dbg_n++; end
          else if (r == 2) begin halted = 1; quit_at = t + 2; end
          else if (r == 3) npc = R[0];
        end
        1:  R[0] = 16'(r);
        2:  R[0] = v;
        3:  if (r == 14) npc = R[0]; else R[r] = R[0];
        4:  R[0] = R[0] + v;
        5:  R[0] = R[0] - v;
        6:  R[0] = R[0] & v;
        7:  R[0] = R[0] | v;
        8:  R[0] = R[0] ^ v;
        9:  R[0] = ~v;
        10: R[0] = (sh >= 16) ? 16'h0 : 16'((32'(R[0]) * (32'd1 << sh)) % 32'h10000);
        11: R[0] = (sh >= 16) ? 16'h0 : 16'(32'(R[0]) / (32'd1 << sh));
        12: begin R[12][0] = (R[0] == v); R[12][1] = (R[0] < v); end
        13: if (R[12][0]) npc = v;
        14: begin R[0] = mm[v[15:1]]; cost = 4; end
        default: begin
          exp_we[t+2] = 1; exp_wa[t+2] = v; exp_wd[t+2] = R[0];
          mm[v[15:1]] = R[0]; exp_st_n++; cost = 3;
        end
      endcase
      pc = npc;
      t += cost;
    end
    model_ok = halted;
  endtask

  task automatic set_prog(input logic [7:0] p [$]);
    for (int i = 0; i < MEMW; i++) img[i] = '0;
    foreach (p[i]) begin
      if (i % 2 == 1) img[i/2][15:8] = p[i];
      else            img[i/2][7:0]  = p[i];
    end
  endtask

  task automatic run_prog(input int dis_at, input int dis_len, input int abort_at);
    int          n, limit, st_seen, dis_left;
    bit          dis_done, held_v;
    logic [15:0] held, qaddr;
    obs_fetch.delete(); obs_wa.delete(); obs_wd.delete();
    dbg_seen = 0; st_seen = 0; n = 0; dis_left = 0; dis_done = 0; held_v = 0;
    held = '0; qaddr = '0;
    reset = 1; enable = 1; load_mem = 1;
    @(posedge clk); #1 load_mem = 0;
    @(posedge clk); #1 reset = 0;
    limit = quit_at + dis_len + 12;
    for (int k = 0; k < limit; k++) begin
      if (abort_at >= 0 && k == abort_at) return;
      if (dis_len > 0 && !dis_done && n == dis_at) begin dis_left = dis_len; dis_done = 1; end
      enable = (dis_left == 0);
      if (dis_left > 0) dis_left--;
      @(negedge clk);
      if (k == 0) begin
        check("reset_addr", 32'(bus.addr), 32'h0);
        check("reset_data_out", 32'(bus.data_out), 32'h0);
      end
      if (enable) begin
        if (held_v) begin check("resume_addr", 32'(bus.addr), 32'(held)); held_v = 0; end
        if (exp_fetch[n] >= 0) begin
          check("fetch_addr", 32'(bus.addr), 32'(exp_fetch[n]));
          obs_fetch.push_back(bus.addr);
        end
        check("write_en", 32'(bus.write_en), 32'(exp_we[n]));
        if (exp_we[n]) begin
          check("store_addr", 32'(bus.addr), 32'(exp_wa[n]));
          check("store_data", 32'(bus.data_out), 32'(exp_wd[n]));
        end
        if (bus.write_en) begin obs_wa.push_back(bus.addr); obs_wd.push_back(bus.data_out); end
        check("debug", 32'(debug), 32'(exp_dbg[n]));
        check("quit", 32'(quit), 32'(n >= quit_at));
        if (n == quit_at) qaddr = bus.addr;
        else if (n > quit_at) check("halt_addr", 32'(bus.addr), 32'(qaddr));
        n++;
      end else begin
        check("frozen_write_en", 32'(bus.write_en), 32'h0);
        check("frozen_debug", 32'(debug), 32'h0);
        check("frozen_quit", 32'(quit), 32'(n >= quit_at));
        if (!held_v) begin held = bus.addr; held_v = 1; end
        else check("frozen_addr", 32'(bus.addr), 32'(held));
      end
      dbg_seen += int'(debug);
      st_seen  += int'(bus.write_en);
      @(posedge clk); #1;
    end
    enable = 1;
    check("debug_count", 32'(dbg_seen), 32'(exp_dbg_n));
    check("store_count", 32'(st_seen), 32'(exp_st_n));
  endtask

  initial begin
    logic [7:0]  prog [$];
    logic [15:0] fseq [7];
    int          first_we;

    // Taken jump: SET 8, CPY R1, CMP R0, JIF R1 -> 8: DEBUG, DEBUG, QUIT.
    prog = '{8'h18, 8'h31, 8'hC0, 8'hD1, 8'h02, 8'h02, 8'h02, 8'h02, 8'h01, 8'h01, 8'h02};
    set_prog(prog);
    model_run();
    run_prog(0, 0, -1);
    fseq = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd8, 16'd9, 16'd10};
    check("jump_fetch_len", 32'(obs_fetch.size()), 32'd7);
    for (int i = 0; i < 7 && i < obs_fetch.size(); i++) check("jump_fetch_seq", 32'(obs_fetch[i]), 32'(fseq[i]));
    check("jump_debugs", 32'(dbg_seen), 32'd2);
    check("jump_quit", 32'(quit), 32'd1);

    // Reset after quit: the same program runs again from PC 0.
    run_prog(0, 0, -1);
    check("rerun_debugs", 32'(dbg_seen), 32'd2);
    check("rerun_first_fetch", 32'(obs_fetch[0]), 32'd0);

    // Not-taken jump: SET 1, CMP R1 (EQ=0), JIF R2, DEBUG, QUIT.
    prog = '{8'h11, 8'hC1, 8'hD2, 8'h01, 8'h02};
    set_prog(prog);
    model_run();
    run_prog(0, 0, -1);
    check("fallthru_debugs", 32'(dbg_seen), 32'd1);
    check("fallthru_fetch3", 32'(obs_fetch[3]), 32'd3);

    // Arithmetic: 7+3 compared with 10, jump to 10, then 0-7 stored at 0.
    prog = '{8'h17, 8'h32, 8'h13, 8'h42, 8'h33, 8'h1A, 8'hC3, 8'hD0,
             8'h02, 8'h02, 8'h01, 8'h10, 8'h52, 8'hFF, 8'h02};
    set_prog(prog);
    model_run();
    run_prog(0, 0, -1);
    check("arith_jump_target", 32'(obs_fetch[8]), 32'd10);
    check("arith_debugs", 32'(dbg_seen), 32'd1);
    check("sub_wrap_addr", 32'(obs_wa[0]), 32'h0000);
    check("sub_wrap_data", 32'(obs_wd[0]), 32'hFFF9);

    // Store/load: build 0x0100 and 0x1234, STORE, clear WR, LOAD, STORE to 0x0200.
    prog = '{8'h18, 8'h32, 8'h11, 8'hA2, 8'h33, 8'h43, 8'h37, 8'h14, 8'h34,
             8'h11, 8'hA4, 8'h35, 8'h12, 8'h75, 8'hA4, 8'h35, 8'h13, 8'h75,
             8'hA4, 8'h35, 8'h14, 8'h75, 8'hF3, 8'h10, 8'hE3, 8'hF7, 8'h02};
    set_prog(prog);
    model_run();
    run_prog(0, 0, -1);
    check("store_n", 32'(obs_wa.size()), 32'd2);
    check("store1_addr", 32'(obs_wa[0]), 32'h0100);
    check("store1_data", 32'(obs_wd[0]), 32'h1234);
    check("load_back_addr", 32'(obs_wa[1]), 32'h0200);
    check("load_back_data", 32'(obs_wd[1]), 32'h1234);

    // Same program frozen for 10 cycles on the STORE strobe, then mid-LOAD.
    first_we = 0;
    while (first_we < MAXC - 1 && !exp_we[first_we]) first_we++;
    run_prog(first_we, 10, -1);
    check("frz_store_data", 32'(obs_wd[0]), 32'h1234);
    run_prog(first_we + 6, 10, -1);
    check("frz_load_data", 32'(obs_wd[1]), 32'h1234);

    // Random straight-line programs (no jumps) ending in QUIT.
    for (int p = 0; p < 8; p++) begin
      model_ok = 0;
      for (int tries = 0; tries < 20 && !model_ok; tries++) begin
        prog.delete();
        for (int i = 0; i < 48; i++) begin
          int op, r;
          op = int'($urandom_range(0, 14));
          r  = int'($urandom_range(0, 15));
          if (op == 13) op = 14;
          else if (op == 14) op = 15;
          if (op == 0) r = int'($urandom_range(0, 1));
          if (op == 3 && r == 14) r = 15;
          prog.push_back(8'((op << 4) | r));
        end
        prog.push_back(8'h02);
        set_prog(prog);
        model_run();
      end
      check("model_halts", 32'(model_ok), 32'd1);
      if (p == 0) run_prog(0, 0, 15);
      if (p == 1) run_prog(20, 10, -1);
      else        run_prog(0, 0, -1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/reflet_cpu_core.md
Name: reflet_cpu_core

Overview:
- Small accumulator-style CPU of the reflet family, with 8-bit instructions and a parameterised data word.
- Connects to a single synchronous memory bus: a ROM or RAM with 1-cycle read latency, addressed by byte.
- Provides simulation/system hooks: a `debug` pulse and a sticky `quit` flag.
- Simulation benches run programs from a ROM and watch `debug` and `quit`.

Parameters:
- wordsize, 16: width of registers, data bus and address bus (supported values 16 and 32).

Ports:
- clk  in  1  system clock; everything is updated on its rising edge.
- reset  in  1  synchronous, active-high. Clears the whole core.
- enable  in  1  when low, the core freezes all state and forces write_en=0.
- interrupt_request  in  4  reserved; ignored by this version.
- data_in  in  wordsize  read data; valid one cycle after addr is driven.
- data_out  out  wordsize  store data; equals WR during a STORE.
- addr  out  wordsize  byte address for fetch, load and store.
- write_en  out  1  high for exactly the single STORE cycle.
- quit  out  1  sticky; set when QUIT executes and cleared only by reset.
- debug  out  1  one-cycle pulse when DEBUG executes.

Behaviour:
- Registers: 16 × wordsize.
  - R0 = WR (accumulator).
  - R1–R11 general purpose.
  - R12 = SR: bit0 = EQ flag, bit1 = LT flag.
  - R13 = SP (plain register in this version).
  - R14 = PC.
  - R15 general purpose.
- Reset (synchronous, clk edge with reset=1): all registers 0, PC=0, state=FETCH, quit=0, debug=0, write_en=0, addr=0, data_out=0.
- Instruction fetch:
  - Instruction byte = data_in[7:0] if PC[0]=0, else data_in[15:8] (little-endian).
  - Memory is word-wide and indexed by addr[wordsize-1:1].
- State machine:
  - FETCH: addr=PC → EXEC.
  - EXEC: decode the byte; PC += 1 unless a jump is taken. Next state is MEM for LOAD/STORE, otherwise FETCH.
  - MEM: LOAD drives addr=Rr and goes to LWAIT; STORE drives addr=Rr, data_out=WR, write_en=1 and goes to FETCH.
  - LWAIT: WR <= data_in → FETCH.
  - HALT: entered after QUIT; no further bus activity.
- Latency: plain instructions take 2 cycles, STORE 3, LOAD 4.
- Opcodes (high nibble op, low nibble r):
  - 0x00 NOP.
  - 0x01 DEBUG: debug=1 for one cycle.
  - 0x02 QUIT: quit=1 → HALT.
  - 0x03 JMP: PC <= WR.
  - 0x04–0x0F NOP.
  - 1 SET: WR <= zero-extended r (immediate value).
  - 2 READ: WR <= Rr.
  - 3 CPY: Rr <= WR.
  - 4 ADD, 5 SUB, 6 AND, 7 OR, 8 XOR: WR <= WR op Rr. Results wrap modulo 2^wordsize; no carry flag.
  - 9 NOT: WR <= ~Rr.
  - A LSL, B LSR: WR shifted by Rr[4:0]. Shifts ≥ wordsize give 0.
  - C CMP: SR[0] <= (WR==Rr); SR[1] <= (WR<Rr) unsigned; other SR bits unchanged.
  - D JIF: if SR[0], PC <= Rr, else PC += 1.
  - E LOAD: WR <= mem[Rr].
  - F STORE: mem[Rr] <= WR.
- Register aliasing:
  - CPY to R14 acts as a jump; the write to PC takes priority over the increment.
  - READ of R14 returns the address of the current instruction.
- Loads and stores are word accesses; the address LSB is ignored for data.
- enable=0 mid-instruction: state, registers and addr hold; write_en=0; debug=0. Execution resumes exactly where it stopped.
- Reset asserted mid-operation (any state, including HALT) aborts the current instruction and applies the reset values on that edge.
- Only one register write per cycle; no hazards arise.

Decomposition:
- Shared package `reflet_pkg` holds:
  - opcode constants (OP_SET … OP_STORE, MISC_NOP/DEBUG/QUIT/JMP);
  - register indices (REG_WR=0, REG_SR=12, REG_SP=13, REG_PC=14);
  - the FSM state enum (FETCH, EXEC, MEM, LWAIT, HALT).
- One natural sub-module, `reflet_alu`: combinational block taking op, WR and Rr and returning the result plus the EQ and LT flags.

Test Plan:
- Taken jump: ROM bytes 18 31 C0 D1 02 02 02 02 01 01 02 starting at address 0.
  - Required: exactly two debug pulses, then quit=1 held high.
  - No bus access after quit; addr sequence 0,1,2,3,8,9,10.
- Not-taken jump: program with SR[0]=0 before JIF (bytes 11 C1 D2 01 02).
  - Required: falls through; one debug pulse, then quit.
- Arithmetic: SET 7, CPY R2, SET 3, ADD R2, CPY R3, SET 10, CMP R3, JIF R0, then DEBUG at the jump target.
  - Required: WR=10 before the compare; CMP sets EQ; the jump to 10 is taken.
  - Also required: SUB wraps, so WR=0 minus R2=7 gives 0xFFF9.
- Store/load: STORE WR=0x1234 to 0x0100, then LOAD from it.
  - Required: write_en high exactly one cycle with addr=0x0100 and data_out=0x1234.
  - Required: WR=0x1234 after LWAIT; STORE takes 3 cycles and LOAD 4.
- enable held low for 10 cycles mid-program.
  - Required: PC, addr and all state frozen, write_en=0; the program completes identically afterwards.
- Reset pulse after quit.
  - Required: quit=0, PC=0 and the program re-executes producing the same debug count.
